// File: rtl/final_permutation_serializer_if.sv
// Block-in / byte-out handshake bundle for the DES final-permutation serializer.
// The master modport drives the block and the byte acceptance; the slave modport is the serializer itself.
interface final_permutation_serializer_if;
   logic [31:0] left_half;
   logic [31:0] right_half;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;
   logic        byte_last;
   logic [15:0] blocks_done;

   modport master (
      output left_half, right_half, in_valid, byte_ready,
      input  in_ready, byte_out, byte_valid, byte_last, blocks_done
   );

   modport slave (
      input  left_half, right_half, in_valid, byte_ready,
      output in_ready, byte_out, byte_valid, byte_last, blocks_done
   );
endinterface

// File: rtl/final_permutation_serializer.sv
// Applies the DES final permutation (IP^-1) to the round-16 halves, queues the result in a 2-deep FIFO
// and streams it out MSB byte first with a valid/ready handshake and a completed-block counter.
module final_permutation_serializer #(
   parameter bit SWAP_HALVES = 1'b1
) (
   input  logic clk,
   input  logic rst,
   final_permutation_serializer_if.slave bus
);
   typedef enum logic {IDLE, SHIFT} state_t;

   state_t      state, state_nxt;
   logic [63:0] fifo_mem [2];
   logic        wr_ptr, rd_ptr;
   logic [1:0]  count;
   logic [63:0] shift_q;
   logic [2:0]  idx;
   logic [15:0] done_q;
   logic        push, pop, fire, fire_last;
   logic [63:0] pre, perm;

   // FIPS numbering: bit n of a 64-bit word is vector index 64-n. Row r, column c of the
   // FP table is 40+4c (even c) or 4+4c (odd c), minus r.
   function automatic logic [63:0] fp(input logic [63:0] p);
      logic [63:0] o;
      int r, c, src;
      o = '0;
      for (int k = 1; k <= 64; k++) begin
         r   = (k - 1) / 8;
         c   = (k - 1) % 8;
         src = (((c % 2) == 0) ? (40 + 4 * c) : (4 + 4 * c)) - r;
         o[64-k] = p[64-src];
      end
      return o;
   endfunction

   assign pre  = SWAP_HALVES ? {bus.right_half, bus.left_half} : {bus.left_half, bus.right_half};
   assign perm = fp(pre);

   assign bus.in_ready    = (count < 2'd2) && !rst;
   assign bus.byte_valid  = (state == SHIFT);
   assign bus.byte_out    = (state == SHIFT) ? shift_q[63:56] : 8'h00;
   assign bus.byte_last   = (state == SHIFT) && (idx == 3'd7);
   assign bus.blocks_done = done_q;

   assign push      = bus.in_valid && bus.in_ready;
   assign fire      = bus.byte_valid && bus.byte_ready;
   assign fire_last = fire && (idx == 3'd7);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // The last-byte handshake pops the next entry in the same cycle so blocks run back to back.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (count != 2'd0) begin
               pop       = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (fire_last) begin
               if (count != 2'd0) pop = 1'b1;
               else               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= 2'd0;
         shift_q <= 64'd0;
         idx     <= 3'd0;
         done_q  <= 16'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if (pop) begin
            shift_q <= fifo_mem[rd_ptr];
            idx     <= 3'd0;
         end else if (fire) begin
            shift_q <= {shift_q[55:0], 8'h00};
            idx     <= idx + 3'd1;
         end
         if (fire_last) done_q <= done_q + 16'd1;
      end
   end

   // Storage needs no reset: an entry is only read while count says it is live.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= perm;
   end
endmodule

// File: doc/final_permutation_serializer.md
FINAL_PERMUTATION_SERIALIZER -- requirements
Module: final_permutation_serializer

Interface
REQ-001 SHALL have parameter SWAP_HALVES, default 1; 1 means the preoutput is {right_half,left_half} (DES R16L16 swap), 0 means {left_half,right_half}.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port left_half, input, 32, the round-16 left half.
REQ-005 SHALL have port right_half, input, 32, the round-16 right half.
REQ-006 SHALL have port in_valid, input, 1, which qualifies left_half/right_half.
REQ-007 SHALL have port in_ready, output, 1, which means a block can be accepted this cycle.
REQ-008 SHALL have port byte_out, output, 8, one ciphertext byte, most significant byte first.
REQ-009 SHALL have port byte_valid, output, 1, which qualifies byte_out.
REQ-010 SHALL have port byte_ready, input, 1, the downstream acceptance of byte_out.
REQ-011 SHALL have port byte_last, output, 1, which marks the 8th byte of a block.
REQ-012 SHALL have port blocks_done, output, 16, the count of fully transmitted blocks.

Function
REQ-013 SHALL apply the DES final permutation FP (IP^-1) to the 64-bit preoutput P, using FIPS numbering (bit 1 = MSB): out bit k = P bit FP[k]; FP row 1 = 40,8,48,16,56,24,64,32; rows 2-8 each subtract 1 from the previous row's entries.
REQ-014 SHALL satisfy FP(IP(x)) = x for every x when SWAP_HALVES=0.
REQ-015 SHALL accept a block on a cycle with in_valid && in_ready, and SHALL store FP(P) into a 2-entry FIFO at that rising edge.
REQ-016 SHALL drive in_ready = (FIFO count < 2) && !rst; there is no full-FIFO pass-through, and in_ready depends only on registered state.
REQ-017 SHALL implement the serializer FSM with states IDLE and SHIFT, a 64-bit shift register and a 3-bit byte index.
REQ-018 In IDLE with the FIFO non-empty, SHALL pop the head into the shift register, set index=0 and go to SHIFT at the next edge.
REQ-019 In SHIFT, SHALL drive byte_valid=1, byte_out = shift[63:56] and byte_last = (index==7).
REQ-020 In SHIFT, byte_out, byte_last and the shift register SHALL hold stable while byte_valid && !byte_ready.
REQ-021 On byte_valid && byte_ready with index<7, SHALL shift left 8 bits and increment index.
REQ-022 On byte_valid && byte_ready with index==7, SHALL increment blocks_done (wrapping 0xFFFF to 0x0000), then load the next FIFO entry and stay in SHIFT with index=0 if one is present, otherwise go to IDLE.
REQ-023 The REQ-022 back-to-back load SHALL give zero bubble cycles between blocks.
REQ-024 SHALL complete a FIFO push and pop in the same cycle correctly, leaving the count unchanged.
REQ-025 Latency: a block accepted in cycle N SHALL present its first byte_valid in cycle N+2 when the serializer is IDLE and the FIFO was empty.
REQ-026 byte_valid SHALL never be asserted in IDLE.
REQ-027 A byte handshake SHALL never be lost or duplicated: exactly 8 byte handshakes per accepted block, in order.

Reset
REQ-028 While rst is high, SHALL force: FIFO count 0, FSM IDLE, index 0, shift register 0, blocks_done 0, byte_valid 0, byte_last 0, byte_out 0x00, in_ready 0.
REQ-029 Reset asserted mid-block SHALL discard the partial block and all FIFO contents immediately, without completing the current byte.
REQ-030 in_ready SHALL rise in the first cycle after rst deasserts.

Verification
REQ-031 Known answer: SWAP_HALVES=1, left=0x43423234, right=0x0A4CD995, byte_ready=1 -> bytes 85 E8 13 54 0F 0A B4 05, byte_last on 05, blocks_done=1.
REQ-032 Round trip: SWAP_HALVES=0, left=0xCC00CCFF, right=0xF0AAF0AA -> bytes 01 23 45 67 89 AB CD EF.
REQ-033 Backpressure: byte_ready=0 -> accept 3 blocks on consecutive cycles -> in_ready low after the 2nd FIFO fill; byte_out is held stable; after release, 24 bytes arrive in order with no bubble between blocks.
REQ-034 Random stall: random byte_ready and in_valid over 1000 blocks -> output stream matches the reference FP model; blocks_done=1000 mod 65536.
REQ-035 Reset mid-block: assert rst after byte 3 with 2 blocks queued -> all outputs reach reset values asynchronously; after deassertion, a new block is emitted cleanly from byte 0.
REQ-036 Counter wrap: preload via 65536 blocks (or force) -> blocks_done returns to 0x0000.
